dmux4x32_stream: RTL



---
 rtl/dmux_pkg.sv | 23 ++
 rtl/chan_fifo.sv | 84 ++++++++
 rtl/dmux4x32_stream.sv | 96 +++++++++
 3 files changed

// File: rtl/dmux_pkg.sv
// rtl/dmux_pkg.sv - shared constants and types for the 1-to-4 stream demultiplexer
package dmux_pkg;

  // Number of consumer channels and the width of the select that addresses them.
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  // Stall counter width and the count at which a persistent stall is flagged.
  localparam int                 STALL_W     = 8;
  localparam logic [STALL_W-1:0] STALL_LIMIT = 8'd255;

  // Channel index, as carried by the producer's select.
  typedef logic [SEL_W-1:0] ch_idx_t;

  // One-hot channel mask for a given select value.
  function automatic logic [NUM_CH-1:0] sel_decode(input ch_idx_t sel);
    logic [NUM_CH-1:0] mask;
    mask      = '0;
    mask[sel] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/chan_fifo.sv
// rtl/chan_fifo.sv - per-channel FIFO with a registered head word that holds while empty
module chan_fifo
  import dmux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  // Pointers wrap naturally because DEPTH is a power of two.
  localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW       = AW + 1;
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);

  // Guard against overflow/underflow even if the caller misbehaves.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign head_o = head_q;

  // Next pointers, occupancy and head word; the head is re-registered so an
  // empty channel keeps showing the last word it delivered.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;

    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // When the slot about to become head is the one being written this
    // cycle, take the incoming word directly instead of stale storage.
    if (count_d != '0) begin
      if (do_push && (wr_ptr_q == rd_ptr_d)) head_d = data_i;
      else                                   head_d = mem_q[rd_ptr_d];
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Control state and head register, cleared immediately on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/dmux4x32_stream.sv
// rtl/dmux4x32_stream.sv - routes one producer stream to four buffered consumer channels
module dmux4x32_stream
  import dmux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic              CLK,
  input  logic              CLRN,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [WIDTH-1:0]  IN_DATA,
  input  ch_idx_t           S,
  output logic [NUM_CH-1:0] OUT_VALID,
  input  logic [NUM_CH-1:0] OUT_READY,
  output logic [WIDTH-1:0]  Y0,
  output logic [WIDTH-1:0]  Y1,
  output logic [WIDTH-1:0]  Y2,
  output logic [WIDTH-1:0]  Y3,
  output logic              DROP_ERR
);

  logic [NUM_CH-1:0] full_w;
  logic [NUM_CH-1:0] empty_w;
  logic [NUM_CH-1:0] push_w;
  logic [NUM_CH-1:0] pop_w;
  logic [WIDTH-1:0]  head_w [NUM_CH];

  logic               accept_w;
  logic               stall_w;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               drop_err_q, drop_err_d;

  // Readiness depends only on the selected channel's registered fill state,
  // so there is no combinational path from any consumer's ready.
  assign IN_READY = !full_w[S];
  assign accept_w = IN_VALID && IN_READY;
  assign push_w   = accept_w ? sel_decode(S) : '0;

  // Each consumer pops independently whenever it has data and is ready.
  assign pop_w     = OUT_READY & ~empty_w;
  assign OUT_VALID = ~empty_w;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    chan_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i   (CLK),
      .rst_ni  (CLRN),
      .push_i  (push_w[k]),
      .pop_i   (pop_w[k]),
      .data_i  (IN_DATA),
      .full_o  (full_w[k]),
      .empty_o (empty_w[k]),
      .head_o  (head_w[k])
    );
  end

  assign Y0 = head_w[0];
  assign Y1 = head_w[1];
  assign Y2 = head_w[2];
  assign Y3 = head_w[3];

  // A stalled cycle is one where the producer offers a word that cannot be taken.
  assign stall_w = IN_VALID && !IN_READY;

  // Count consecutive stalled cycles (saturating) and latch the error once the
  // stall runs past the limit; any non-stalled cycle restarts the count.
  always_comb begin
    stall_cnt_d = '0;
    drop_err_d  = drop_err_q;
    if (stall_w) begin
      if (stall_cnt_q == STALL_LIMIT) begin
        stall_cnt_d = stall_cnt_q;
        drop_err_d  = 1'b1;
      end else begin
        stall_cnt_d = stall_cnt_q + STALL_W'(1);
      end
    end
  end

  // Stall counter and sticky error flag.
  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      stall_cnt_q <= '0;
      drop_err_q  <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      drop_err_q  <= drop_err_d;
    end
  end

  assign DROP_ERR = drop_err_q;

endmodule
